// File: rtl/urisc_param.sv
// -----------------------------------------------------------------------------
// urisc_param
// One-instruction (subtract-and-branch-if-negative) processor core with
// parametrised data width, register count and program address width.
//
// Each instruction runs FE -> LD -> DC -> EX. Register 0 is the input port:
// reading it returns in_data, and it is never written. Register NREG-1 drives
// the output port through a valid/ready handshake. A word with rd==rs and
// mode==1 is HALT and parks the core until reset.
//
// Instruction word (IW = 2*RA+1+AW bits): { rd[RA], rs[RA], mode, addr[AW] }
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   imem_addr  out  AW  program address (always equals pc)
//   imem_data  in   IW  program word, valid one cycle after imem_addr
//   in_data    in   DW  input port data (register 0 reads)
//   in_valid   in   1   in_data valid
//   in_ready   out  1   core consumes in_data this cycle (combinational)
//   out_data   out  DW  output port, mirrors r[NREG-1]
//   out_valid  out  1   new out_data pending
//   out_ready  in   1   sink accepts out_data
//   halted     out  1   core stopped on HALT
//   jump       out  1   branch taken by last executed instruction
//   dif        out  DW  low DW bits of last result
// -----------------------------------------------------------------------------
module urisc_param #(
  parameter int DW         = 8,
  parameter int RA         = 4,
  parameter int AW         = 7,
  parameter int REL_SIGNED = 0,
  localparam int IW        = 2 * RA + 1 + AW,
  localparam int NREG      = 2 ** RA
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          halted,
  output logic          jump,
  output logic [DW-1:0] dif
);

  typedef enum logic [2:0] {FE, LD, DC, EX, HLT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;

  // Decoded fields, latched in DC and held stable for the whole EX stall.
  logic [RA-1:0] rd;
  logic [RA-1:0] rs;
  logic          mode;
  logic [AW-1:0] addr;

  logic [DW-1:0] r [NREG];

  logic [RA-1:0] ir_rd;
  logic [RA-1:0] ir_rs;
  logic          halt_word;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW:0]   result;
  logic          need_i;
  logic          blk_o;
  logic          complete;
  logic [AW-1:0] pc_rel;
  logic [AW-1:0] pc_next;

  assign imem_addr = pc;
  assign out_data  = r[NREG-1];

  assign ir_rd     = ir[IW-1 -: RA];
  assign ir_rs     = ir[IW-1-RA -: RA];
  assign halt_word = (ir_rd == ir_rs) && ir[AW];

  // Register 0 aliases the input port on either operand.
  assign a = (rd == '0) ? in_data : r[rd];
  assign b = (rs == '0) ? in_data : r[rs];

  // One guard bit so the sign of the true difference survives overflow.
  assign result = {a[DW-1], a} - {b[DW-1], b};

  assign need_i   = (rd == '0) || (rs == '0);
  assign blk_o    = (rd == '1) && out_valid && !out_ready;
  assign in_ready = (state == EX) && need_i && !blk_o;
  assign complete = (state == EX) && !blk_o && (!need_i || in_valid);

  // At width AW a sign-extended and a zero-extended offset wrap to the same
  // pc; both forms are kept so the intent of each mode stays explicit.
  assign pc_rel  = (REL_SIGNED != 0) ? AW'($signed(pc) + $signed(addr))
                                     : AW'(pc + addr);
  assign pc_next = !result[DW] ? AW'(pc + AW'(1))
                 : mode        ? addr
                 :               pc_rel;

  // NOTE: every sequential assignment below is non-blocking so all state
  // updates in a cycle see the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FE;
      pc        <= '0;
      ir        <= '0;
      rd        <= '0;
      rs        <= '0;
      mode      <= 1'b0;
      addr      <= '0;
      // NOTE: the register file is reset on purpose; -1 in every register is
      // the architected power-up value and out_data depends on it.
      for (int i = 0; i < NREG; i++) r[i] <= '1;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      jump      <= 1'b0;
      dif       <= '0;
    end else begin
      // An accepted output clears; a completing write below overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;

      unique case (state)
        FE: state <= LD;
        LD: begin
          ir    <= imem_data;
          state <= DC;
        end
        DC: begin
          rd   <= ir_rd;
          rs   <= ir_rs;
          mode <= ir[AW];
          addr <= ir[AW-1:0];
          if (halt_word) begin
            halted <= 1'b1;
            state  <= HLT;
          end else begin
            state  <= EX;
          end
        end
        EX: begin
          if (complete) begin
            if (rd != '0) r[rd] <= result[DW-1:0];
            if (rd == '1) out_valid <= 1'b1;
            jump  <= result[DW];
            dif   <= result[DW-1:0];
            pc    <= pc_next;
            state <= FE;
          end
        end
        HLT:     state <= HLT;
        default: state <= FE;
      endcase
    end
  end

endmodule
